config_frame_readback: RTL and testbench

Reads configuration frames back out of a fabric column's configuration latches so that the configured state can be checked against the written bitstream. The block drives the one-hot frame select of a column, waits for the latch outputs to settle through the column read path, and captures one frame word per select. It streams the words out on a valid/ready interface and closes each burst with an XOR checksum word. It sits beside the frame writer in the configuration controller and shares the column's frame-select lines with it, under controller arbitration.

---
 rtl/config_frame_readback_if.sv | 16 +
 rtl/config_frame_readback.sv | 136 +++++++++++++
 tb/tb_config_frame_readback.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_frame_readback_if.sv
// Output stream bundle for config_frame_readback.
//   m_data  : frame word or checksum word
//   m_valid : beat valid
//   m_ready : downstream accept
//   m_last  : marks the checksum beat that closes a burst
interface config_frame_readback_if #(
    parameter int unsigned FRAME_BITS = 32
) ();
    logic [FRAME_BITS-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/config_frame_readback.sv
// Reads configuration frames of one fabric column back through the one-hot
// frame select, streams one word per frame and closes each burst with an
// XOR checksum beat.
//   CLK, resetn  : clock, synchronous active-low reset
//   rb_start     : burst request (sampled in IDLE only)
//   rb_first     : first frame index of the burst
//   rb_count     : number of frames (1..FRAMES_PER_COL)
//   rb_busy      : burst in progress
//   rb_err       : one-cycle pulse on a rejected request
//   frame_sel    : one-hot column frame select, zero when not selecting
//   frame_rdata  : column latch readback data
//   m            : output stream (data/valid/last out, ready in)
module config_frame_readback #(
    parameter int unsigned FRAME_BITS     = 32,
    parameter int unsigned FRAMES_PER_COL = 20,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned IDX_W          = $clog2(FRAMES_PER_COL)
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      rb_start,
    input  logic [IDX_W-1:0]          rb_first,
    input  logic [IDX_W:0]            rb_count,
    output logic                      rb_busy,
    output logic                      rb_err,
    output logic [FRAMES_PER_COL-1:0] frame_sel,
    input  logic [FRAME_BITS-1:0]     frame_rdata,
    config_frame_readback_if.master   m
);

    localparam int unsigned CNT_W    = IDX_W + 1;
    // One extra bit over the count width so first+count can never wrap.
    localparam int unsigned SUM_W    = IDX_W + 2;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CAPTURE,
        SEND,
        SUM
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      remaining;
    logic [SETTLE_W-1:0]   settle;
    logic [FRAME_BITS-1:0] csum;

    logic [SUM_W-1:0]      req_end_c;
    logic                  req_bad_c;
    logic                  hs_c;

    // Request legality: non-empty and fully inside the column.
    assign req_end_c = SUM_W'(rb_first) + SUM_W'(rb_count);
    assign req_bad_c = (rb_count == '0) || (req_end_c > SUM_W'(FRAMES_PER_COL));
    assign hs_c      = m.m_valid && m.m_ready;

    // Readback sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            settle    <= '0;
            csum      <= '0;
            frame_sel <= '0;
            rb_busy   <= 1'b0;
            rb_err    <= 1'b0;
            m.m_data  <= '0;
            m.m_valid <= 1'b0;
            m.m_last  <= 1'b0;
        end else begin
            rb_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rb_start) begin
                        if (req_bad_c) begin
                            rb_err <= 1'b1;
                        end else begin
                            idx       <= rb_first;
                            remaining <= rb_count;
                            csum      <= '0;
                            settle    <= SETTLE_W'(SETTLE_CYCLES - 1);
                            frame_sel <= FRAMES_PER_COL'(1) << rb_first;
                            rb_busy   <= 1'b1;
                            state     <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    if (settle == '0) begin
                        state <= CAPTURE;
                    end else begin
                        settle <= settle - SETTLE_W'(1);
                    end
                end
                CAPTURE: begin
                    m.m_data  <= frame_rdata;
                    csum      <= csum ^ frame_rdata;
                    remaining <= remaining - CNT_W'(1);
                    idx       <= idx + IDX_W'(1);
                    frame_sel <= '0;
                    m.m_valid <= 1'b1;
                    m.m_last  <= 1'b0;
                    state     <= SEND;
                end
                SEND: begin
                    if (hs_c) begin
                        if (remaining != '0) begin
                            m.m_valid <= 1'b0;
                            frame_sel <= FRAMES_PER_COL'(1) << idx;
                            settle    <= SETTLE_W'(SETTLE_CYCLES - 1);
                            state     <= SELECT;
                        end else begin
                            // csum already includes the last captured word.
                            m.m_data  <= csum;
                            m.m_last  <= 1'b1;
                            state     <= SUM;
                        end
                    end
                end
                SUM: begin
                    if (hs_c) begin
                        m.m_valid <= 1'b0;
                        m.m_last  <= 1'b0;
                        rb_busy   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_readback.sv
// Scoreboard bench for config_frame_readback: directed bursts push expected
// beats; a negedge monitor pops and compares every accepted beat and checks
// stream stability and frame_sel invariants.
module tb_config_frame_readback;

    localparam int unsigned FB  = 32;
    localparam int unsigned NF  = 20;
    localparam int unsigned IW  = 5;

    logic          CLK;
    logic          resetn;
    logic          rb_start;
    logic [IW-1:0] rb_first;
    logic [IW:0]   rb_count;
    logic          rb_busy;
    logic          rb_err;
    logic [NF-1:0] frame_sel;
    logic [FB-1:0] frame_rdata;

    logic [FB-1:0] col_mem [NF];
    int            ready_mode;   // 0: always ready, 1: 0,0,1 per beat, 2: never
    logic          bp_ready;
    int            stall_cnt;

    int            n_checks;
    int            n_fail;
    logic [FB:0]   exp_q [$];

    logic          hold;
    logic [FB:0]   hold_beat;

    config_frame_readback_if #(.FRAME_BITS(FB)) bus ();

    config_frame_readback #(
        .FRAME_BITS     (FB),
        .FRAMES_PER_COL (NF),
        .SETTLE_CYCLES  (2)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .rb_start    (rb_start),
        .rb_first    (rb_first),
        .rb_count    (rb_count),
        .rb_busy     (rb_busy),
        .rb_err      (rb_err),
        .frame_sel   (frame_sel),
        .frame_rdata (frame_rdata),
        .m           (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Column model: the selected frame's latch contents, garbage otherwise.
    always_comb begin
        frame_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < int'(NF); i++) begin
            if (frame_sel[i]) frame_rdata = col_mem[i];
        end
    end

    assign bus.m_ready = (ready_mode == 0) ? 1'b1 :
                         (ready_mode == 1) ? bp_ready : 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backpressure pattern: two stalled cycles, then accept.
    initial begin
        bp_ready  = 1'b0;
        stall_cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.m_valid) begin
                if (stall_cnt == 2) begin
                    bp_ready  = 1'b1;
                    stall_cnt = 0;
                end else begin
                    bp_ready  = 1'b0;
                    stall_cnt++;
                end
            end else begin
                bp_ready  = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor: invariants, stall stability and scoreboard compare.
    initial begin
        hold      = 1'b0;
        hold_beat = '0;
        forever begin
            @(negedge CLK);
            if (resetn) begin
                chk("sel_onehot", 64'($countones(frame_sel) > 1), 64'd0);
                if (bus.m_valid) chk("sel_zero_while_valid", 64'(frame_sel), 64'd0);
                if (hold)
                    chk("stall_hold", 64'({bus.m_valid, bus.m_last, bus.m_data}),
                        64'({1'b1, hold_beat}));
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'({bus.m_last, bus.m_data}), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("beat", 64'({bus.m_last, bus.m_data}), 64'(exp_q.pop_front()));
                    end
                end
                hold      = bus.m_valid && !bus.m_ready;
                hold_beat = {bus.m_last, bus.m_data};
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Issue a start; returns #1 into cycle 1 (the cycle after the start edge).
    task automatic start(input int first, input int count);
        @(posedge CLK);
        #1;
        rb_first = IW'(first);
        rb_count = (IW+1)'(count);
        rb_start = 1'b1;
        @(posedge CLK);
        #1;
        rb_start = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!rb_busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk("burst_done_in_budget", 64'(done), 64'd1);
    endtask

    initial begin
        resetn     = 1'b0;
        rb_start   = 1'b0;
        rb_first   = '0;
        rb_count   = '0;
        ready_mode = 0;
        n_checks   = 0;
        n_fail     = 0;
        for (int i = 0; i < int'(NF); i++) col_mem[i] = FB'(i);

        repeat (3) step();
        chk("rst_frame_sel", 64'(frame_sel), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_last", 64'(bus.m_last), 64'd0);
        chk("rst_m_data", 64'(bus.m_data), 64'd0);
        chk("rst_busy_err", 64'({rb_busy, rb_err}), 64'd0);
        resetn = 1'b1;

        // Single frame, exact cycle timing.
        col_mem[5] = 32'hA5A5_0F0F;
        exp_q.push_back({1'b0, 32'hA5A5_0F0F});
        exp_q.push_back({1'b1, 32'hA5A5_0F0F});
        start(5, 1);
        chk("t1_c1_sel", 64'(frame_sel), 64'h00020);
        chk("t1_c1_busy", 64'(rb_busy), 64'd1);
        step();
        chk("t1_c2_sel", 64'(frame_sel), 64'h00020);
        step();
        chk("t1_c3_sel", 64'(frame_sel), 64'h00020);
        chk("t1_c3_valid", 64'(bus.m_valid), 64'd0);
        step();
        chk("t1_c4_valid_last", 64'({bus.m_valid, bus.m_last}), 64'b10);
        chk("t1_c4_sel", 64'(frame_sel), 64'd0);
        step();
        chk("t1_c5_valid_last", 64'({bus.m_valid, bus.m_last}), 64'b11);
        chk("t1_c5_busy", 64'(rb_busy), 64'd1);
        step();
        chk("t1_c6_busy", 64'(rb_busy), 64'd0);
        chk("t1_c6_valid", 64'(bus.m_valid), 64'd0);
        col_mem[5] = 32'd5;

        // Full column; XOR of 0..19 is 0.
        for (int i = 0; i < int'(NF); i++) exp_q.push_back({1'b0, FB'(i)});
        exp_q.push_back({1'b1, 32'h0000_0000});
        start(0, 20);
        wait_idle(200);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure, 3 frames.
        col_mem[7] = 32'h1111_0000;
        col_mem[8] = 32'h0000_2222;
        col_mem[9] = 32'h4444_4444;
        exp_q.push_back({1'b0, 32'h1111_0000});
        exp_q.push_back({1'b0, 32'h0000_2222});
        exp_q.push_back({1'b0, 32'h4444_4444});
        exp_q.push_back({1'b1, 32'h5555_6666});
        ready_mode = 1;
        start(7, 3);
        wait_idle(100);
        ready_mode = 0;
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 7; i < 10; i++) col_mem[i] = FB'(i);

        // Illegal requests.
        start(18, 3);
        chk("t4a_err", 64'(rb_err), 64'd1);
        chk("t4a_busy_sel", 64'({rb_busy, frame_sel}), 64'd0);
        step();
        chk("t4a_err_one_cycle", 64'(rb_err), 64'd0);
        chk("t4a_busy_sel2", 64'({rb_busy, frame_sel}), 64'd0);
        start(0, 0);
        chk("t4b_err", 64'(rb_err), 64'd1);
        chk("t4b_busy_sel", 64'({rb_busy, frame_sel}), 64'd0);
        step();
        chk("t4b_err_one_cycle", 64'(rb_err), 64'd0);

        // Reset during SEND of the second of four frames.
        exp_q.push_back({1'b0, 32'd0});
        start(0, 4);
        begin
            int seen;
            bit hit;
            seen = 0;
            hit  = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (bus.m_valid) seen++;
                if (seen == 2) begin
                    hit = 1'b1;
                    break;
                end
                step();
            end
            chk("t5_reached_frame2", 64'(hit), 64'd1);
        end
        chk("t5_pre_rst_data", 64'(bus.m_data), 64'd1);
        ready_mode = 2;
        resetn     = 1'b0;
        step();
        chk("t5_rst_sel", 64'(frame_sel), 64'd0);
        chk("t5_rst_stream", 64'({bus.m_valid, bus.m_last, bus.m_data}), 64'd0);
        chk("t5_rst_busy_err", 64'({rb_busy, rb_err}), 64'd0);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
        resetn     = 1'b1;
        ready_mode = 0;
        col_mem[3] = 32'hCAFE_F00D;
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        start(3, 1);
        wait_idle(50);
        chk("t5_post_q_empty", 64'(exp_q.size()), 64'd0);

        // Start while busy is ignored.
        col_mem[10] = 32'h0F0F_0000;
        col_mem[11] = 32'h00F0_F0F0;
        exp_q.push_back({1'b0, 32'h0F0F_0000});
        exp_q.push_back({1'b0, 32'h00F0_F0F0});
        exp_q.push_back({1'b1, 32'h0FFF_F0F0});
        start(10, 2);
        rb_first = 5'd0;
        rb_count = 6'd0;
        rb_start = 1'b1;
        step();
        rb_start = 1'b0;
        chk("t6_no_err", 64'(rb_err), 64'd0);
        chk("t6_sel_unchanged", 64'(frame_sel), 64'h00400);
        wait_idle(50);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
